// File: rtl/cpu_mem_bridge_if.sv
// CPU request port and wait-stated memory bus seen by cpu_mem_bridge.
// slave is the bridge's view; master is the CPU/memory environment's view.
`ifndef ENUM__CPU_WH_RDWR__READ
`define ENUM__CPU_WH_RDWR__READ 1'b0
`endif
`ifndef ENUM__CPU_WH_RDWR__WRITE
`define ENUM__CPU_WH_RDWR__WRITE 1'b1
`endif

interface cpu_mem_bridge_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  cpu_req_rdwr;
   logic                  cpu_which_rdwr;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_data_out;
   logic [DATA_WIDTH-1:0] cpu_data_in;
   logic                  cpu_enable;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic                  bus_err;
   logic                  busy;

   modport slave (
      input  cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
      output cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata, bus_err, busy
   );

   modport master (
      output cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
      input  cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata, bus_err, busy
   );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Turns each CPU memory request into one req/ack memory transaction, stalling
// the CPU through cpu_enable and aborting with a sticky bus_err on timeout.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for cpu_req_rdwr; CPU enabled only if no request
// XFER  | mem_req held, counting cycles until mem_ack or timeout
// DONE  | one cycle with cpu_enable high so the CPU consumes data
`ifndef ENUM__CPU_WH_RDWR__READ
`define ENUM__CPU_WH_RDWR__READ 1'b0
`endif
`ifndef ENUM__CPU_WH_RDWR__WRITE
`define ENUM__CPU_WH_RDWR__WRITE 1'b1
`endif

module cpu_mem_bridge #(
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    TIMEOUT_CYCLES = 16,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   cpu_mem_bridge_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q,    state_d;
   logic                  mem_req_q,  mem_req_d;
   logic                  mem_we_q,   mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
   logic                  bus_err_q,  bus_err_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_data_d  = cpu_data_q;
      bus_err_d   = bus_err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req_rdwr) begin
               mem_addr_d  = bus.cpu_addr;
               mem_wdata_d = bus.cpu_data_out;
               mem_we_d    = (bus.cpu_which_rdwr == `ENUM__CPU_WH_RDWR__WRITE);
               mem_req_d   = 1'b1;
               cnt_d       = '0;
               state_d     = XFER;
            end
         end
         XFER: begin
            // ack on the final counted cycle still completes normally
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) cpu_data_d = bus.mem_rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (!mem_we_q) cpu_data_d = TIMEOUT_DATA;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_data_q  <= '0;
         bus_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_data_q  <= cpu_data_d;
         bus_err_q   <= bus_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // a new request stalls the CPU in the very cycle it first appears
   assign bus.cpu_enable  = rst && (((state_q == IDLE) && !bus.cpu_req_rdwr) || (state_q == DONE));
   assign bus.busy        = (state_q != IDLE);
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.cpu_data_in = cpu_data_q;
   assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: CPU driver, behavioural RAM responder,
// and a DONE-cycle monitor checking returned data against queued expectations.
`ifndef ENUM__CPU_WH_RDWR__READ
`define ENUM__CPU_WH_RDWR__READ 1'b0
`endif
`ifndef ENUM__CPU_WH_RDWR__WRITE
`define ENUM__CPU_WH_RDWR__WRITE 1'b1
`endif

module tb_cpu_mem_bridge;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } mtxn_t;

   typedef struct {
      logic [7:0] data;
      logic       err;
   } res_t;

   logic clk;
   logic rst;
   logic resp_ack;
   logic stray_ack;

   int checks;
   int failures;

   mtxn_t mexp_q[$];
   res_t  res_q[$];
   int    wait_q[$];
   logic [7:0] ram [bit [15:0]];

   cpu_mem_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

   cpu_mem_bridge #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(8'hFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.mem_ack = resp_ack | stray_ack;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // memory responder: acks after the queued number of wait states (-1 = never)
   initial begin
      int    cyc;
      int    w;
      bit    active;
      mtxn_t cur;
      resp_ack      = 1'b0;
      bus.mem_rdata = 8'h00;
      active        = 1'b0;
      cyc           = 0;
      w             = 0;
      cur           = '{1'b0, 16'h0, 8'h0};
      forever begin
         @(negedge clk);
         resp_ack = 1'b0;
         if (!rst) begin
            active = 1'b0;
         end else if (bus.mem_req) begin
            if (!active) begin
               active = 1'b1;
               cyc    = 0;
               w      = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
               if (mexp_q.size() == 0) begin
                  chk("mem_unexpected_txn", {15'd0, bus.mem_we, bus.mem_addr}, 32'hFFFF_FFFF);
               end else begin
                  cur = mexp_q.pop_front();
                  chk("mem_txn", {7'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                      {7'd0, cur.we, cur.addr, cur.wdata});
               end
            end else begin
               chk("mem_hold", {7'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                   {7'd0, cur.we, cur.addr, cur.wdata});
            end
            if (w >= 0 && cyc == w) begin
               resp_ack = 1'b1;
               if (cur.we) ram[cur.addr] = cur.wdata;
               else bus.mem_rdata = ram.exists(cur.addr) ? ram[cur.addr] : 8'h00;
            end
            cyc++;
         end else begin
            active = 1'b0;
         end
      end
   end

   // result monitor: DONE is the only cycle with busy and cpu_enable both high
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rst && bus.busy && bus.cpu_enable) begin
            if (res_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = res_q.pop_front();
               chk("cpu_data_in", {24'd0, bus.cpu_data_in}, {24'd0, e.data});
               chk("bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
            end
         end
      end
   end

   task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] ed, input bit ee);
      int low;
      int exp_low;
      bit done;
      exp_low = (waits < 0) ? 17 : waits + 2;
      @(negedge clk);
      res_q.push_back('{ed, ee});
      mexp_q.push_back('{we, a, wd});
      wait_q.push_back(waits);
      bus.cpu_req_rdwr   = 1'b1;
      bus.cpu_which_rdwr = we ? `ENUM__CPU_WH_RDWR__WRITE : `ENUM__CPU_WH_RDWR__READ;
      bus.cpu_addr       = a;
      bus.cpu_data_out   = wd;
      #1;
      chk("enable_stall_first_cycle", {31'd0, bus.cpu_enable}, 32'd0);
      low  = 1;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.cpu_enable) done = 1'b1;
         else low++;
      end
      bus.cpu_req_rdwr = 1'b0;
      if (!done) chk("enable_wait_bound", 32'd0, 32'd1);
      chk("enable_low_cycles", low, exp_low);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      stray_ack = 1'b0;
      bus.cpu_req_rdwr   = 1'b0;
      bus.cpu_which_rdwr = `ENUM__CPU_WH_RDWR__READ;
      bus.cpu_addr       = 16'h0;
      bus.cpu_data_out   = 8'h0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #12;
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_cpu_enable", {31'd0, bus.cpu_enable}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
      chk("rst_outputs", {bus.mem_addr, bus.mem_wdata, bus.cpu_data_in}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("idle_cpu_enable", {31'd0, bus.cpu_enable}, 32'd1);

      ram[16'hF000] = 8'h45;
      ram[16'h0200] = 8'h3C;
      ram[16'h1235] = 8'h22;
      ram[16'h0010] = 8'h5A;

      // zero-wait read, then 3-wait write leaving cpu_data_in untouched
      cpu_op(1'b0, 16'hF000, 8'h00, 0, 8'h45, 1'b0);
      cpu_op(1'b1, 16'hF500, 8'h87, 3, 8'h45, 1'b0);

      // ack on the 16th XFER cycle completes normally
      ram[16'hF000] = 8'h00;
      cpu_op(1'b0, 16'h0200, 8'h00, 15, 8'h3C, 1'b0);

      // stray ack while idle
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      chk("stray_ack_busy", {31'd0, bus.busy}, 32'd0);
      chk("stray_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
      @(negedge clk);
      chk("stray_ack_busy_after", {31'd0, bus.busy}, 32'd0);

      // CPU-like store/store/load/load with random wait states
      cpu_op(1'b1, 16'hF000, 8'h45, int'($urandom_range(5)), 8'h3C, 1'b0);
      cpu_op(1'b1, 16'hF500, 8'h87, int'($urandom_range(5)), 8'h3C, 1'b0);
      cpu_op(1'b0, 16'hF000, 8'h00, int'($urandom_range(5)), 8'h45, 1'b0);
      cpu_op(1'b0, 16'hF500, 8'h00, int'($urandom_range(5)), 8'h87, 1'b0);

      // timeout then a normal read with bus_err sticky
      cpu_op(1'b0, 16'h1234, 8'h00, -1, 8'hFF, 1'b1);
      cpu_op(1'b0, 16'h1235, 8'h00, 2, 8'h22, 1'b1);
      @(negedge clk);
      chk("bus_err_sticky", {31'd0, bus.bus_err}, 32'd1);

      // reset during the 2nd XFER cycle
      @(negedge clk);
      mexp_q.push_back('{1'b0, 16'h0300, 8'h00});
      wait_q.push_back(-1);
      bus.cpu_req_rdwr   = 1'b1;
      bus.cpu_which_rdwr = `ENUM__CPU_WH_RDWR__READ;
      bus.cpu_addr       = 16'h0300;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("async_rst_cpu_enable", {31'd0, bus.cpu_enable}, 32'd0);
      bus.cpu_req_rdwr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("post_rst_state", {bus.bus_err, bus.cpu_data_in}, 32'd0);
      cpu_op(1'b0, 16'h0010, 8'h00, 1, 8'h5A, 1'b0);

      repeat (3) @(negedge clk);
      chk("results_drained", res_q.size(), 32'd0);
      chk("mem_txns_drained", mexp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the CPU core's memory request port (req_rdwr / which_rdwr / addr / data_out / data_in / enable).
- Converts each CPU request into a single transaction on a wait-stated req/ack memory bus.
- Stalls the CPU through its enable input until the transaction completes, then returns read data on the CPU's data_in.
- Bounds every transaction with a timeout and a sticky error flag.

Parameters:
ADDR_WIDTH, 16, CPU/memory address width (16-bit address space for now)
DATA_WIDTH, 8, data byte width
TIMEOUT_CYCLES, 16, maximum XFER cycles without mem_ack before abort (>=1)
TIMEOUT_DATA, 8'hFF, value returned to the CPU on a timed-out read

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous, active-low; clears all state immediately on assertion
cpu_req_rdwr  in  1  CPU requests a read or write this cycle
cpu_which_rdwr  in  1  `ENUM__CPU_WH_RDWR__READ or `ENUM__CPU_WH_RDWR__WRITE
cpu_addr  in  ADDR_WIDTH  request address
cpu_data_out  in  DATA_WIDTH  write data from the CPU
cpu_data_in  out  DATA_WIDTH  read data to the CPU, registered
cpu_enable  out  1  CPU enable; low stalls the CPU
mem_req  out  1  memory transaction request, registered
mem_we  out  1  1 = write, 0 = read, registered
mem_addr  out  ADDR_WIDTH  memory address, registered
mem_wdata  out  DATA_WIDTH  memory write data, registered
mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ack = 1
mem_ack  in  1  transaction complete, single-cycle pulse
bus_err  out  1  sticky timeout flag, registered
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, cpu_data_in, bus_err, timeout counter all 0.
  - cpu_enable forced 0 while rst is low.
- FSM states: IDLE, XFER, DONE.
- cpu_enable is combinational: 1 iff (state == IDLE and cpu_req_rdwr == 0) or state == DONE.
  - So the CPU never advances in the same cycle a new request is first visible.
- IDLE:
  - cpu_req_rdwr = 1 at the edge: latch cpu_addr into mem_addr and cpu_data_out into mem_wdata.
  - Set mem_we = (cpu_which_rdwr == WRITE), mem_req = 1, counter = 0, go to XFER.
  - Otherwise remain in IDLE.
- Each CPU-enabled cycle with cpu_req_rdwr high counts as one new request. A level held across consecutive enabled cycles issues consecutive transactions; there is no edge detection.
- XFER:
  - mem_req, mem_we, mem_addr, mem_wdata are held stable.
  - mem_ack = 1 at the edge:
    - mem_req <= 0.
    - On a read, cpu_data_in <= mem_rdata. On a write, cpu_data_in is unchanged.
    - Go to DONE.
  - mem_ack = 0 and counter == TIMEOUT_CYCLES-1:
    - mem_req <= 0, bus_err <= 1.
    - On a read, cpu_data_in <= TIMEOUT_DATA.
    - Go to DONE.
  - Otherwise counter <= counter + 1.
  - mem_ack on the timeout cycle wins: normal completion, no bus_err.
- DONE: exactly one cycle with cpu_enable = 1, so the CPU consumes cpu_data_in and steps. Unconditionally go to IDLE.
- Latency, request first visible in cycle N:
  - XFER begins at N+1. With zero-wait ack (ack during the first XFER cycle), DONE is at N+2.
  - cpu_enable is low for N and N+1 (2 cycles minimum); each memory wait state adds 1 cycle.
- mem_ack in IDLE or DONE: ignored, no state change.
- bus_err is cleared only by reset.
- Reset mid-XFER: mem_req drops asynchronously. The transaction is abandoned; the memory side must tolerate the dropped request.
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits, no wrap before abort.

Test Plan:
1. Read, zero wait: CPU read 0xF000, mem_ack with mem_rdata = 0x45 in the first XFER cycle -> mem_req high 1 cycle with mem_we = 0, mem_addr = 0xF000; cpu_enable low exactly 2 cycles; cpu_data_in = 0x45 in DONE.
2. Write, 3 wait states: CPU write 0x87 to 0xF500, ack in the 4th XFER cycle -> mem_we = 1, mem_addr = 0xF500, mem_wdata = 0x87 stable for 4 cycles; cpu_enable low 5 cycles; cpu_data_in unchanged.
3. Timeout: read 0x1234 with mem_ack never asserted, TIMEOUT_CYCLES = 16 -> mem_req high exactly 16 cycles; bus_err = 1 and stays 1; cpu_data_in = 0xFF. A following read acked with 0x22 returns 0x22 while bus_err remains 1.
4. CPU-like sequence: store 0x45 to 0xF000, store 0x87 to 0xF500, load 0xF000, load 0xF500 against a behavioural RAM with random 0-5 wait states -> mem transactions occur in that exact order, and the loads return 0x45 then 0x87.
5. Edge cases: ack on the timeout cycle yields data and bus_err = 0; a stray mem_ack pulse in IDLE causes no transaction and no state change.
6. Reset mid-transfer: rst driven low during the 2nd XFER cycle -> mem_req, busy and cpu_enable go 0 without waiting for clk. After release, a new read of 0x0010 acked with 0x5A completes normally with cpu_data_in = 0x5A.
